// File: rtl/nibble_bank_ctrl_pkg.sv
// nibble_bank_ctrl_pkg: shared defaults and types for the nibble bank.
//   DEPTH_D / W_D / AW_D : default geometry (256 x 4-bit, 8-bit address)
//   CW                   : count width, one wider than the address so DEPTH fits
//   bank_state_t         : fill state of the bank, tracks count
package nibble_bank_ctrl_pkg;
  localparam int DEPTH_D = 256;
  localparam int W_D     = 4;
  localparam int AW_D    = 8;
  localparam int CW      = AW_D + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;
endpackage

// File: rtl/nibble_bank_ctrl_select.sv
// nibble_select: combinational DEPTH:1 select of one W-bit entry.
//   bus  : flat DEPTH*W storage image, entry i at bits [i*W +: W]
//   sel  : entry index
//   data : selected entry
module nibble_select #(
  parameter int DEPTH = 256,
  parameter int W     = 4,
  parameter int AW    = 8
) (
  input  logic [DEPTH*W-1:0] bus,
  input  logic [AW-1:0]      sel,
  output logic [W-1:0]       data
);
  // Packed 2-D view lets the select be a plain index.
  logic [DEPTH-1:0][W-1:0] words;

  assign words = bus;
  assign data  = words[sel];
endmodule

// File: rtl/nibble_bank_ctrl.sv
// nibble_bank_ctrl: 256 x 4-bit nibble bank, serially filled, randomly read.
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous flush (count -> 0, no write that cycle)
//   wr_valid/ready/data : fill stream, written at entry count
//   rd_req_valid/ready  : read request handshake, rd_addr selects the entry
//   rd_rsp_valid/ready  : registered response handshake, rd_data / rd_miss
//   count, full, empty  : fill level and its decoded state
module nibble_bank_ctrl
  import nibble_bank_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int W     = W_D,
  parameter int AW    = AW_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_rsp_valid,
  input  logic          rd_rsp_ready,
  output logic [W-1:0]  rd_data,
  output logic          rd_miss,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  logic [DEPTH-1:0][W-1:0] bank;
  bank_state_t             state;
  logic                    wr_acc, rd_acc, miss;
  logic [W-1:0]            sel_data;

  assign full         = (state == FULL);
  assign empty        = (state == EMPTY);
  assign wr_ready     = !full;
  assign wr_acc       = wr_valid && wr_ready && !clear;
  assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
  assign rd_acc       = rd_req_valid && rd_req_ready;
  // Judged on the pre-write count, so reading the entry being written misses.
  assign miss         = ({1'b0, rd_addr} >= count);

  // Storage carries no reset; entries at or above count are never returned.
  always_ff @(posedge clk) begin
    if (wr_acc) bank[count[AW-1:0]] <= wr_data;
  end

  // Fill state and count move together; only a write or clear changes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      state <= EMPTY;
    end else if (clear) begin
      count <= '0;
      state <= EMPTY;
    end else if (wr_acc) begin
      count <= count + 1'b1;
      state <= (count == LAST) ? FULL : FILLING;
    end
  end

  nibble_select #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_sel (
    .bus  (bank),
    .sel  (rd_addr),
    .data (sel_data)
  );

  // Single-entry response register; clear deliberately does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rsp_valid <= 1'b0;
      rd_data      <= '0;
      rd_miss      <= 1'b0;
    end else if (rd_acc) begin
      rd_rsp_valid <= 1'b1;
      rd_miss      <= miss;
      rd_data      <= miss ? '0 : sel_data;
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
  end
endmodule
